// File: rtl/vx_gbar_unit.sv
// ============================================================================
//  Module   : vx_gbar_unit
//  Brief    : Cluster-level global barrier unit. It tracks arrivals for each
//             barrier ID and emits a one-cycle broadcast release.
//             Optional perf counters are enabled by defining VX_GBAR_PERF_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vx_gbar_unit #(
   parameter int NUM_BARRIERS = 16,
   parameter int NUM_CORES    = 8,
   parameter int ID_W         = $clog2(NUM_BARRIERS),
   parameter int CORE_W       = $clog2(NUM_CORES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [ID_W-1:0]   req_id,
   input  logic [CORE_W-1:0] req_size_m1,
   input  logic [CORE_W-1:0] req_core_id,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [ID_W-1:0]   rsp_id,
   output logic              err_dup,
   output logic              err_size
`ifdef VX_GBAR_PERF_EN
   ,
   output logic [31:0]       perf_releases,
   output logic [31:0]       perf_wait_cycles
`endif
);

   localparam int CNT_W = CORE_W + 1;

   // A barrier is in GATHER exactly when its arrival mask is non-zero, so the
   // mask itself encodes the IDLE/GATHER state.
   logic [NUM_CORES-1:0] arr_mask    [NUM_BARRIERS];
   logic [CORE_W-1:0]    arr_size_m1 [NUM_BARRIERS];

   logic [NUM_CORES-1:0] cur_mask;
   logic [NUM_CORES-1:0] core_bit;
   logic [NUM_CORES-1:0] new_mask;
   logic [CORE_W-1:0]    stored_size;
   logic [CORE_W-1:0]    size_eff;
   logic [CNT_W-1:0]     target_cnt;
   logic                 idle;
   logic                 dup;
   logic                 core_oor;
   logic                 fire;
   logic                 accept;
   logic                 any_gather;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CORES-1:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
      return cnt;
   endfunction

   always_comb begin
      cur_mask    = arr_mask[req_id];
      stored_size = arr_size_m1[req_id];
      core_bit    = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         core_bit[i] = (int'(req_core_id) == i);
      end
      core_oor   = (int'(req_core_id) >= NUM_CORES);
      idle       = (cur_mask == '0);
      dup        = |(cur_mask & core_bit);
      new_mask   = cur_mask | core_bit;
      size_eff   = idle ? req_size_m1 : stored_size;
      target_cnt = {1'b0, size_eff} + CNT_W'(1);
      fire       = (popcount(new_mask) == target_cnt);
      accept     = req_valid && req_ready;
   end

   always_comb begin
      any_gather = 1'b0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         any_gather = any_gather | (|arr_mask[b]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            arr_mask[b]    <= '0;
            arr_size_m1[b] <= '0;
         end
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         err_dup   <= 1'b0;
         err_size  <= 1'b0;
      end else begin
         req_ready <= 1'b1;
         rsp_valid <= accept && !core_oor && fire;
         if (accept) begin
            if (core_oor || dup) begin
               err_dup <= 1'b1;
            end
            // Out-of-range cores are dropped without touching barrier state.
            if (!core_oor) begin
               if (!idle && (req_size_m1 != stored_size)) begin
                  err_size <= 1'b1;
               end
               if (idle) begin
                  arr_size_m1[req_id] <= req_size_m1;
               end
               arr_mask[req_id] <= fire ? '0 : new_mask;
               if (fire) begin
                  rsp_id <= req_id;
               end
            end
         end
      end
   end

`ifdef VX_GBAR_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_releases    <= '0;
         perf_wait_cycles <= '0;
      end else begin
         if (rsp_valid) begin
            perf_releases <= perf_releases + 32'd1;
         end
         if (any_gather) begin
            perf_wait_cycles <= perf_wait_cycles + 32'd1;
         end
      end
   end
`else
   logic unused_gather;
   assign unused_gather = any_gather;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vx_gbar_unit.sv
// ============================================================================
//  Module   : tb_vx_gbar_unit
//  Brief    : Self-checking bench for vx_gbar_unit; releases are predicted into
//             a scoreboard queue and popped when rsp_valid is sampled.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vx_gbar_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [3:0] req_id = '0;
   logic [2:0] req_size_m1 = '0;
   logic [2:0] req_core_id = '0;
   logic       req_ready;
   logic       rsp_valid;
   logic [3:0] rsp_id;
   logic       err_dup;
   logic       err_size;
`ifdef VX_GBAR_PERF_EN
   logic [31:0] perf_releases;
   logic [31:0] perf_wait_cycles;
`endif

   int total  = 0;
   int passed = 0;
   int exp_q[$];

   vx_gbar_unit dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_id      (req_id),
      .req_size_m1 (req_size_m1),
      .req_core_id (req_core_id),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .err_dup     (err_dup),
      .err_size    (err_size)
`ifdef VX_GBAR_PERF_EN
      ,
      .perf_releases    (perf_releases),
      .perf_wait_cycles (perf_wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One request (or idle cycle when v=0); rel marks a predicted release.
   task automatic step(input logic v, input int id, input int size, input int core,
                       input bit rel, input string tag);
      int e;
      req_valid   = v;
      req_id      = 4'(id);
      req_size_m1 = 3'(size);
      req_core_id = 3'(core);
      if (rel) exp_q.push_back(id);
      @(posedge clk);
      #1;
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (rsp_valid) chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(e));
      end
      req_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.rsp_valid", 32'(rsp_valid), 0);
      chk("rst.rsp_id",    32'(rsp_id),    0);
      chk("rst.err_dup",   32'(err_dup),   0);
      chk("rst.err_size",  32'(err_size),  0);
      chk("rst.req_ready", 32'(req_ready), 0);
`ifdef VX_GBAR_PERF_EN
      chk("rst.perf_rel",  perf_releases,    0);
      chk("rst.perf_wait", perf_wait_cycles, 0);
`endif
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(req_ready), 1);

      // Single-participant barrier, then a fresh generation on the same ID
      step(1, 3, 0, 5, 1, "single");
      step(1, 3, 1, 0, 0, "regen_a");
      step(1, 3, 1, 1, 1, "regen_b");
      step(0, 0, 0, 0, 0, "idle0");
      chk("single.err_dup",  32'(err_dup),  0);
      chk("single.err_size", 32'(err_size), 0);

      // Four-core gather on id 7
      step(1, 7, 3, 0, 0, "g7_c0");
      step(1, 7, 3, 1, 0, "g7_c1");
      step(1, 7, 3, 2, 0, "g7_c2");
      step(1, 7, 3, 3, 1, "g7_c3");
      step(0, 0, 0, 0, 0, "g7_after");

      // Interleaved ids 1 and 2 -> back-to-back releases
      step(1, 1, 1, 0, 0, "il_1a");
      step(1, 2, 1, 4, 0, "il_2a");
      step(1, 1, 1, 2, 1, "il_1b");
      step(1, 2, 1, 6, 1, "il_2b");
      step(0, 0, 0, 0, 0, "il_after");

      // Duplicate arrival on id 4
      step(1, 4, 1, 2, 0, "dup_a");
      chk("dup.err_dup_pre", 32'(err_dup), 0);
      step(1, 4, 1, 2, 0, "dup_b");
      chk("dup.err_dup", 32'(err_dup), 1);
      step(1, 4, 1, 5, 1, "dup_c");
      chk("dup.err_dup_sticky", 32'(err_dup), 1);

      // Size mismatch on id 6: stored size 2 governs
      step(1, 6, 2, 0, 0, "sz_a");
      step(1, 6, 3, 1, 0, "sz_b");
      chk("sz.err_size", 32'(err_size), 1);
      step(1, 6, 2, 2, 1, "sz_c");
      chk("sz.err_size_sticky", 32'(err_size), 1);

      // Reset mid-gather on id 5 discards partial mask
      step(1, 5, 2, 0, 0, "mr_a");
      step(1, 5, 2, 1, 0, "mr_b");
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mr.rsp_valid", 32'(rsp_valid), 0);
      chk("mr.err_dup",   32'(err_dup),   0);
      chk("mr.err_size",  32'(err_size),  0);
`ifdef VX_GBAR_PERF_EN
      chk("mr.perf_wait", perf_wait_cycles, 0);
      chk("mr.perf_rel",  perf_releases,    0);
`endif
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mr.ready", 32'(req_ready), 1);
      step(1, 5, 2, 2, 0, "mr_c");
      step(1, 5, 2, 3, 0, "mr_d");
      step(1, 5, 2, 4, 1, "mr_e");
      step(0, 0, 0, 0, 0, "mr_after");
`ifdef VX_GBAR_PERF_EN
      chk("perf.releases", perf_releases,    1);
      chk("perf.wait",     perf_wait_cycles, 2);
`endif

      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
